floor_indicator_seq: RTL and testbench
======================================

# floor_indicator_seq

Parametrised, clocked successor to the combinational floor decoder: filters N one-hot landing-sensor inputs, tracks the last valid floor and direction of travel, and drives two active-low seven-segment displays. HEX0 shows the floor digit, 'H' (between floors), 'E' (sensor fault) or '-' (unknown). HEX1 shows the direction. It sits between the board switches/sensors and the HEX outputs of the elevator top level.

## Interface
- N_FLOORS, 4 — number of landing sensors; legal 2..9
- STABLE_CYCLES, 4 — consecutive identical samples required before a sensor pattern is accepted; ≥1
- BLINK_CYCLES, 25_000_000 — half-period of the between-floors blink (used only with BLINK_EN)
- CLOCK_50  in  1 — sole clock; all logic on its rising edge
- RESET  in  1 — synchronous, active-high reset
- SW  in  N_FLOORS — raw sensor vector; bit i high = cabin at floor i+1
- HEX0  out  7 — floor display, active-low, bit0=a … bit6=g
- HEX1  out  7 — direction display, active-low
- floor  out  4 — last valid floor, 1..N_FLOORS; 0 = unknown
- floor_valid  out  1 — high only in AT_FLOOR
- fault  out  1 — high only in FAULT

## Operation
- Filter: register SW into sample register `s`. If SW == s, increment stability counter, saturating at STABLE_CYCLES; else load 0. When counter == STABLE_CYCLES-1 and SW == s, copy s into `filt` on that edge. With STABLE_CYCLES=1, `filt` follows SW one cycle after `s`.
- Classification of `filt`: zero = BETWEEN; exactly one bit = FLOOR(i+1); more than one bit = MULTI.
- FSM states: UNKNOWN (reset), AT_FLOOR, BETWEEN, FAULT.
  - UNKNOWN: FLOOR → AT_FLOOR; MULTI → FAULT; BETWEEN → stay.
  - AT_FLOOR: zero → BETWEEN; MULTI → FAULT; different floor → AT_FLOOR with new floor.
  - BETWEEN: FLOOR → AT_FLOOR; MULTI → FAULT.
  - FAULT: FLOOR → AT_FLOOR; zero → BETWEEN if floor≠0, else UNKNOWN.
- Floor update on entering AT_FLOOR with new f:
  - f > floor and floor≠0 → dir=UP
  - f < floor → dir=DOWN
  - f == floor, or floor was 0 → dir=IDLE
  - Then floor ← f.
- FAULT does not change floor or dir.
- HEX0 codes:
  - digits 1..9 use standard active-low codes (1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19 …)
  - 'H'=7'h09, 'E'=7'h06, '-'=7'h3F, blank=7'h7F
- HEX0 by state: AT_FLOOR → digit(floor); BETWEEN → 'H'; FAULT → 'E'; UNKNOWN → '-'.
- HEX1 by dir: UP → 'U'=7'h41; DOWN → 'd'=7'h21; IDLE → blank. Blank in UNKNOWN and FAULT.

## Timing
- All outputs registered.
- Reset values: state=UNKNOWN, floor=0, dir=IDLE, floor_valid=0, fault=0, HEX0=7'h3F, HEX1=7'h7F; s, `filt`, counters cleared.
- Latency: a SW change held constant is reflected on outputs exactly STABLE_CYCLES+2 edges after it appears. Edges are: s capture, STABLE_CYCLES filter, FSM/output register.
- Glitches shorter than STABLE_CYCLES samples never reach `filt`.
- RESET mid-travel wins over everything on that edge; history is lost and floor returns to 0.
- Floor skip (1 → 3 without seeing 2) is legal: dir=UP.

## Configuration
- BETWEEN_BLINK_EN defined:
  - In BETWEEN with floor≠0, HEX0 alternates digit(floor) / 'H' every BLINK_CYCLES clocks, starting with 'H'.
  - The blink counter clears on every entry to BETWEEN and on RESET.
- Not defined: HEX0 is steady 'H' in BETWEEN and no blink counter exists.

## Structure
- Package floor_indicator_pkg:
  - state enum
  - dir enum
  - seven-segment constants: SEG_H, SEG_E, SEG_DASH, SEG_BLANK, SEG_U, SEG_D
  - function seg_digit(4-bit) → 7-bit active-low code
- One sub-module: sensor_filter. Parameters N, STABLE_CYCLES; ports CLOCK_50, RESET, SW, filt. Reusable for other switch inputs.

## Test plan
All cases use N_FLOORS=4, STABLE_CYCLES=4, BLINK_CYCLES=8.
- RESET held 2 cycles, SW=0 → HEX0=7'h3F, HEX1=7'h7F, floor=0, fault=0.
- SW=4'b0001 held → after 6 edges HEX0=7'h79, floor=1, floor_valid=1, HEX1 blank; then SW=0 then 4'b0100 → 'H', then HEX0=7'h30, HEX1=7'h41.
- At floor 3, pulse SW=4'b0000 for 3 cycles then back to 4'b0100 → outputs never change.
- At floor 3, SW=4'b0101 held → HEX0=7'h06, fault=1, HEX1 blank, floor stays 3. Then SW=4'b0010 → floor=2, HEX1=7'h21.
- RESET asserted while BETWEEN after floor 2 → next edge all reset values; re-arrival at floor 2 gives HEX1 blank (IDLE).
- BETWEEN_BLINK_EN defined, BETWEEN after floor 2 → HEX0 = 7'h09 for 8 cycles, 7'h24 for 8 cycles, repeating.

Source files
------------

// File: rtl/floor_indicator_pkg.sv
// Shared types and seven-segment codes for the floor indicator.
package floor_indicator_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN  = 2'd0,
        ST_AT_FLOOR = 2'd1,
        ST_BETWEEN  = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // Active-low segment codes, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_D     = 7'h21;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/floor_indicator_seq_sensor_filter.sv
// Debounce filter: a pattern is accepted once it has been sampled STABLE_CYCLES+1 times in a row.
module sensor_filter #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic [N-1:0] SW,
    output logic [N-1:0] filt
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_TC  = CW'(STABLE_CYCLES - 1);

    logic [N-1:0]  s_q, s_d;
    logic [N-1:0]  filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s_d    = SW;
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (SW == s_q) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_TC) filt_d = s_q;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s_q    <= '0;
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            s_q    <= s_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/floor_indicator_seq.sv
// Floor/direction tracker driving two active-low seven-segment displays.
// Optional BETWEEN_BLINK_EN: blink floor digit / 'H' while travelling.
//
// state       | meaning
// ST_UNKNOWN  | no floor seen since reset
// ST_AT_FLOOR | exactly one landing sensor active
// ST_BETWEEN  | no sensor active, last floor known
// ST_FAULT    | more than one sensor active
module floor_indicator_seq
    import floor_indicator_pkg::*;
#(
    parameter int N_FLOORS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_CYCLES  = 25_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [N_FLOORS-1:0] SW,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [3:0]          floor,
    output logic                floor_valid,
    output logic                fault
);
    if (N_FLOORS < 2 || N_FLOORS > 9 || STABLE_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("floor_indicator_seq: illegal parameter value");
    end

    logic [N_FLOORS-1:0] filt;

    sensor_filter #(
        .N             (N_FLOORS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sensor_filter (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .SW       (SW),
        .filt     (filt)
    );

    logic [3:0] filt_floor;
    logic       filt_zero;
    logic       filt_multi;
    dir_t       arrive_dir;

    always_comb begin
        filt_floor = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (filt[i]) filt_floor = 4'(i + 1);
        end
        filt_zero  = (filt == '0);
        filt_multi = !filt_zero && ((filt & (filt - N_FLOORS'(1))) != '0);
    end

    state_t     state_q, state_d;
    logic [3:0] floor_q, floor_d;
    dir_t       dir_q, dir_d;

    // Direction is judged against the last valid floor; first arrival is always idle.
    always_comb begin
        if (floor_q != 4'd0 && filt_floor > floor_q) arrive_dir = DIR_UP;
        else if (filt_floor < floor_q)                arrive_dir = DIR_DOWN;
        else                                          arrive_dir = DIR_IDLE;
    end

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_UNKNOWN: begin
                if (filt_multi) begin
                    state_d = ST_FAULT;
                end else if (!filt_zero) begin
                    state_d = ST_AT_FLOOR;
                    floor_d = filt_floor;
                    dir_d   = arrive_dir;
                end
            end
            ST_AT_FLOOR: begin
                if (filt_zero) begin
                    state_d = ST_BETWEEN;
                end else if (filt_multi) begin
                    state_d = ST_FAULT;
                end else if (filt_floor != floor_q) begin
                    floor_d = filt_floor;
                    dir_d   = arrive_dir;
                end
            end
            ST_BETWEEN: begin
                if (filt_multi) begin
                    state_d = ST_FAULT;
                end else if (!filt_zero) begin
                    state_d = ST_AT_FLOOR;
                    floor_d = filt_floor;
                    dir_d   = arrive_dir;
                end
            end
            ST_FAULT: begin
                if (filt_zero) begin
                    state_d = (floor_q != 4'd0) ? ST_BETWEEN : ST_UNKNOWN;
                end else if (!filt_multi) begin
                    state_d = ST_AT_FLOOR;
                    floor_d = filt_floor;
                    dir_d   = arrive_dir;
                end
            end
            default: state_d = ST_UNKNOWN;
        endcase
    end

    logic show_digit;

`ifdef BETWEEN_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    // Phase 0 shows 'H'; every entry to BETWEEN restarts on that phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (state_d == ST_BETWEEN) begin
            if (state_q != ST_BETWEEN) begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b0;
            end else if (blink_cnt_q == BLINK_TC) begin
                blink_cnt_d = '0;
                blink_ph_d  = !blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        show_digit = blink_ph_d && (floor_d != 4'd0);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end
`else
    assign show_digit = 1'b0;
`endif

    logic [6:0] hex0_q, hex0_d;
    logic [6:0] hex1_q, hex1_d;
    logic       valid_q, valid_d;
    logic       fault_q, fault_d;

    always_comb begin
        unique case (state_d)
            ST_AT_FLOOR: hex0_d = seg_digit(floor_d);
            ST_BETWEEN:  hex0_d = show_digit ? seg_digit(floor_d) : SEG_H;
            ST_FAULT:    hex0_d = SEG_E;
            default:     hex0_d = SEG_DASH;
        endcase
        hex1_d = SEG_BLANK;
        if (state_d == ST_AT_FLOOR || state_d == ST_BETWEEN) begin
            if (dir_d == DIR_UP)        hex1_d = SEG_U;
            else if (dir_d == DIR_DOWN) hex1_d = SEG_D;
        end
        valid_d = (state_d == ST_AT_FLOOR);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_UNKNOWN;
            floor_q <= '0;
            dir_q   <= DIR_IDLE;
            hex0_q  <= SEG_DASH;
            hex1_q  <= SEG_BLANK;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign HEX0        = hex0_q;
    assign HEX1        = hex1_q;
    assign floor       = floor_q;
    assign floor_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_floor_indicator_seq.sv
// Self-checking bench for floor_indicator_seq: scripted scenarios plus randomized sensor traffic.
module tb_floor_indicator_seq;
    localparam int N      = 4;
    localparam int STABLE = 4;
    localparam int BLINK  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic [6:0]   hex0, hex1;
    logic [3:0]   floor_o;
    logic         floor_valid, fault;

    int errors = 0;
    int checks = 0;

    floor_indicator_seq #(
        .N_FLOORS      (N),
        .STABLE_CYCLES (STABLE),
        .BLINK_CYCLES  (BLINK)
    ) dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .SW          (sw),
        .HEX0        (hex0),
        .HEX1        (hex1),
        .floor       (floor_o),
        .floor_valid (floor_valid),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: spec rules in plain terms, not the RTL structure.
    typedef enum {M_UNK, M_AT, M_BTW, M_FLT} mmode_t;
    mmode_t       m_mode;
    int           m_floor;
    int           m_dir;       // +1 up, -1 down, 0 idle
    int           m_btw_cycles;
    logic [N-1:0] m_last, m_filt;
    int           m_run;       // consecutive identical samples of m_last
    bit           started = 1'b0;

    function automatic logic [6:0] digit_code(input int d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [6:0] exp_hex0();
        logic [6:0] v;
        case (m_mode)
            M_AT:  v = digit_code(m_floor);
            M_BTW: begin
                v = 7'h09;
`ifdef BETWEEN_BLINK_EN
                if (m_floor != 0 && ((m_btw_cycles / BLINK) % 2 == 1)) v = digit_code(m_floor);
`endif
            end
            M_FLT: v = 7'h06;
            default: v = 7'h3F;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] exp_hex1();
        if (m_mode != M_AT && m_mode != M_BTW) return 7'h7F;
        if (m_dir > 0) return 7'h41;
        if (m_dir < 0) return 7'h21;
        return 7'h7F;
    endfunction

    task automatic model_fsm(input logic [N-1:0] f);
        int     ones;
        int     fl;
        mmode_t prev;
        ones = $countones(f);
        fl   = 0;
        for (int i = 0; i < N; i++) if (f[i]) fl = i + 1;
        prev = m_mode;
        if (ones > 1) begin
            m_mode = M_FLT;
        end else if (ones == 1) begin
            if (!(prev == M_AT && fl == m_floor)) begin
                if (m_floor != 0 && fl > m_floor) m_dir = 1;
                else if (fl < m_floor)            m_dir = -1;
                else                              m_dir = 0;
                m_floor = fl;
            end
            m_mode = M_AT;
        end else if (prev == M_FLT) begin
            m_mode = (m_floor != 0) ? M_BTW : M_UNK;
        end else if (prev != M_UNK) begin
            m_mode = M_BTW;
        end
        if (m_mode == M_BTW) m_btw_cycles = (prev == M_BTW) ? m_btw_cycles + 1 : 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started      = 1'b1;
            m_mode       = M_UNK;
            m_floor      = 0;
            m_dir        = 0;
            m_btw_cycles = 0;
            m_last       = '0;
            m_run        = 1;
            m_filt       = '0;
        end else if (started) begin
            model_fsm(m_filt);
            if (sw == m_last) m_run++;
            else begin
                m_last = sw;
                m_run  = 1;
            end
            if (m_run == STABLE + 1) m_filt = sw;
            if (m_run > STABLE + 1) m_run = STABLE + 2;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("hex0",        {1'b0, hex0},  {1'b0, exp_hex0()});
            chk("hex1",        {1'b0, hex1},  {1'b0, exp_hex1()});
            chk("floor",       {4'b0, floor_o}, 8'(m_floor));
            chk("floor_valid", {7'b0, floor_valid}, {7'b0, m_mode == M_AT});
            chk("fault",       {7'b0, fault}, {7'b0, m_mode == M_FLT});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int           hold;
        int           kind;
        logic [N-1:0] prev_sw;
        logic [6:0]   exp_b;

        rst = 1'b1;
        sw  = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_hex0",  {1'b0, hex0}, 8'h3F);
        chk("rst_hex1",  {1'b0, hex1}, 8'h7F);
        chk("rst_floor", {4'b0, floor_o}, 8'h00);
        chk("rst_fault", {7'b0, fault}, 8'h00);
        tick(6);

        sw = 4'b0001;
        tick(5);
        chk("latency_early_hex0", {1'b0, hex0}, 8'h3F);
        tick(1);
        chk("f1_hex0",  {1'b0, hex0}, 8'h79);
        chk("f1_floor", {4'b0, floor_o}, 8'h01);
        chk("f1_valid", {7'b0, floor_valid}, 8'h01);
        chk("f1_hex1",  {1'b0, hex1}, 8'h7F);

        sw = 4'b0000;
        tick(6);
        chk("btw_hex0", {1'b0, hex0}, 8'h09);
        sw = 4'b0100;
        tick(6);
        chk("f3_hex0",  {1'b0, hex0}, 8'h30);
        chk("f3_hex1",  {1'b0, hex1}, 8'h41);
        chk("f3_floor", {4'b0, floor_o}, 8'h03);

        sw = 4'b0000;
        tick(3);
        sw = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            chk("glitch_hex0", {1'b0, hex0}, 8'h30);
            tick(1);
        end

        sw = 4'b0101;
        tick(6);
        chk("flt_hex0",  {1'b0, hex0}, 8'h06);
        chk("flt_fault", {7'b0, fault}, 8'h01);
        chk("flt_hex1",  {1'b0, hex1}, 8'h7F);
        chk("flt_floor", {4'b0, floor_o}, 8'h03);
        sw = 4'b0010;
        tick(6);
        chk("f2_floor", {4'b0, floor_o}, 8'h02);
        chk("f2_hex1",  {1'b0, hex1}, 8'h21);
        chk("f2_hex0",  {1'b0, hex0}, 8'h24);

        sw = 4'b0000;
        tick(6);
        for (int k = 0; k < 4 * BLINK; k++) begin
            exp_b = 7'h09;
`ifdef BETWEEN_BLINK_EN
            if ((k / BLINK) % 2 == 1) exp_b = 7'h24;
`endif
            chk("btw2_hex0", {1'b0, hex0}, {1'b0, exp_b});
            tick(1);
        end

        rst = 1'b1;
        tick(1);
        chk("midrst_hex0",  {1'b0, hex0}, 8'h3F);
        chk("midrst_hex1",  {1'b0, hex1}, 8'h7F);
        chk("midrst_floor", {4'b0, floor_o}, 8'h00);
        chk("midrst_valid", {7'b0, floor_valid}, 8'h00);
        rst = 1'b0;
        sw  = 4'b0010;
        tick(6);
        chk("rearr_floor", {4'b0, floor_o}, 8'h02);
        chk("rearr_hex1",  {1'b0, hex1}, 8'h7F);
        chk("rearr_hex0",  {1'b0, hex0}, 8'h24);

        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
            end
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 12);
            prev_sw = sw;
            if (kind <= 2) begin
                sw = '0;
            end else if (kind <= 7) begin
                sw = N'(1) << $urandom_range(0, N - 1);
            end else if (kind == 8) begin
                do sw = N'($urandom_range(0, (1 << N) - 1)); while ($countones(sw) < 2);
            end else begin
                sw = N'($urandom_range(0, (1 << N) - 1));
                tick($urandom_range(1, STABLE - 1));
                sw = prev_sw;
            end
            tick(hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
